svm_classify_engine: RTL and testbench

Parametrised successor to the SVM top-level classification path: a support-vector store plus a sequential decision-function engine. It holds up to NSV support vectors, each with an alpha, a multi-feature vector and a label. For each test vector it computes score = bias + Σ y_i·alpha_i·(x_i·xtest) with a linear kernel, one support vector per cycle, and returns the sign as Class. The trainer/output memory fills the store through the load port; the classifier result goes to the system output.

---
 rtl/svm_classify_engine_if.sv | 49 ++++
 rtl/svm_classify_engine.sv | 146 ++++++++++++++
 tb/tb_svm_classify_engine.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/svm_classify_engine_if.sv
// svm_classify_engine_if
//   Bundles the support-vector load port, the test-vector port and the
//   classification result port of svm_classify_engine.
//   master : the system side (trainer, test source, result sink)
//   slave  : the classification engine
//   Load port   : sv_wr, sv_ready, sv_alpha, sv_x, sv_y, sv_clear, sv_count, sv_full
//   Test port   : bias, test_valid, test_ready, Xtest
//   Result port : class_valid, class_ready, Class, score
interface svm_classify_engine_if #(
    parameter int NF  = 2,
    parameter int FW  = 9,
    parameter int AW  = 9,
    parameter int NSV = 64
);
    localparam int DW    = 2 * FW + $clog2(NF) + 1;
    localparam int ACC_W = DW + AW + $clog2(NSV) + 2;
    localparam int CW    = $clog2(NSV + 1);

    logic                sv_wr;
    logic                sv_ready;
    logic [AW-1:0]       sv_alpha;
    logic [NF*FW-1:0]    sv_x;
    logic                sv_y;
    logic                sv_clear;
    logic [CW-1:0]       sv_count;
    logic                sv_full;
    logic [ACC_W-1:0]    bias;
    logic                test_valid;
    logic                test_ready;
    logic [NF*FW-1:0]    Xtest;
    logic                class_valid;
    logic                class_ready;
    logic [1:0]          Class;
    logic [ACC_W-1:0]    score;

    modport master (
        output sv_wr, sv_alpha, sv_x, sv_y, sv_clear,
        output bias, test_valid, Xtest, class_ready,
        input  sv_ready, sv_count, sv_full, test_ready,
        input  class_valid, Class, score
    );

    modport slave (
        input  sv_wr, sv_alpha, sv_x, sv_y, sv_clear,
        input  bias, test_valid, Xtest, class_ready,
        output sv_ready, sv_count, sv_full, test_ready,
        output class_valid, Class, score
    );
endinterface

// File: rtl/svm_classify_engine.sv
// svm_classify_engine
//   Linear-kernel SVM decision engine with an internal support-vector store.
//   Computes score = bias + sum_i y_i * alpha_i * (x_i . xtest), one support
//   vector per clock, and reports sign(score) as Class.
//   Ports:
//     mClk    : clock, rising edge
//     mResetn : asynchronous active-low reset (also empties the store)
//     bus     : svm_classify_engine_if.slave (load, test and result ports)
module svm_classify_engine #(
    parameter int NF  = 2,
    parameter int FW  = 9,
    parameter int AW  = 9,
    parameter int NSV = 64
) (
    input  logic                   mClk,
    input  logic                   mResetn,
    svm_classify_engine_if.slave   bus
);
    localparam int DW    = 2 * FW + $clog2(NF) + 1;
    localparam int ACC_W = DW + AW + $clog2(NSV) + 2;
    localparam int CW    = $clog2(NSV + 1);
    localparam int IW    = (NSV > 1) ? $clog2(NSV) : 1;
    localparam int XW    = NF * FW;
    localparam int EW    = AW + XW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [XW-1:0]           xt_q, xt_d;
    logic [EW-1:0]           mem_q [NSV];
    logic [EW-1:0]           mem_d [NSV];

    logic                    full;
    logic [EW-1:0]           entry;
    logic [AW-1:0]           alpha;
    logic [XW-1:0]           sx;
    logic                    y;
    logic signed [DW-1:0]    dot;
    logic signed [ACC_W-1:0] dot_ext;
    logic signed [ACC_W-1:0] alpha_ext;
    logic signed [ACC_W-1:0] term_mag;
    logic signed [ACC_W-1:0] term;

    assign full = (count_q == CW'(NSV));

    // Datapath: the entry addressed by idx is read combinationally and its
    // signed contribution to the decision value is formed in full precision.
    always_comb begin
        entry = mem_q[idx_q[IW-1:0]];
        alpha = entry[AW-1:0];
        sx    = entry[AW +: XW];
        y     = entry[EW-1];
        dot   = '0;
        for (int k = 0; k < NF; k++) begin
            dot = dot + DW'(signed'(sx[k*FW +: FW])) * DW'(signed'(xt_q[k*FW +: FW]));
        end
        dot_ext   = ACC_W'(dot);
        alpha_ext = ACC_W'({1'b0, alpha});
        term_mag  = dot_ext * alpha_ext;
        term      = y ? term_mag : -term_mag;
    end

    // Control: loads and clears only in IDLE; a test offered in IDLE always
    // wins over a simultaneous write. An empty store still spends one ACCUM
    // cycle (adding nothing) so the result appears one edge after acceptance.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        xt_d    = xt_q;
        mem_d   = mem_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.test_valid) begin
                    xt_d    = bus.Xtest;
                    acc_d   = signed'(bus.bias);
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end
                if (bus.sv_clear) begin
                    count_d = '0;
                end else if (bus.sv_wr && !full && !bus.test_valid) begin
                    mem_d[count_q[IW-1:0]] = {bus.sv_y, bus.sv_x, bus.sv_alpha};
                    count_d = count_q + CW'(1);
                end
            end
            ST_ACCUM: begin
                if (count_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    acc_d = acc_q + term;
                    idx_d = idx_q + CW'(1);
                    if (idx_q == count_q - CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.class_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and accumulator state; reset also empties the store.
    always_ff @(posedge mClk or negedge mResetn) begin
        if (!mResetn) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            xt_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            xt_q    <= xt_d;
        end
    end

    // Store contents are never reset; only sv_count decides what is valid.
    always_ff @(posedge mClk) begin
        mem_q <= mem_d;
    end

    assign bus.sv_ready    = (state_q == ST_IDLE) && !full;
    assign bus.sv_count    = count_q;
    assign bus.sv_full     = full;
    assign bus.test_ready  = (state_q == ST_IDLE);
    assign bus.class_valid = (state_q == ST_DONE);
    assign bus.score       = (state_q == ST_DONE) ? acc_q : '0;
    assign bus.Class       = (state_q != ST_DONE) ? 2'b00 :
                             (acc_q == '0)        ? 2'b00 :
                             acc_q[ACC_W-1]       ? 2'b11 : 2'b01;
endmodule

// File: tb/tb_svm_classify_engine.sv
// tb_svm_classify_engine
//   Self-checking bench for svm_classify_engine: table-driven known vectors,
//   randomized stores and tests against an arithmetic reference model, and
//   hand-written corner sequences (empty/full store, backpressure, reset).
module tb_svm_classify_engine;
    localparam int NF    = 2;
    localparam int FW    = 9;
    localparam int AW    = 9;
    localparam int NSV   = 64;
    localparam int DW    = 2 * FW + $clog2(NF) + 1;
    localparam int ACC_W = DW + AW + $clog2(NSV) + 2;

    logic mClk    = 1'b0;
    logic mResetn = 1'b1;

    always #5 mClk = ~mClk;

    svm_classify_engine_if #(.NF(NF), .FW(FW), .AW(AW), .NSV(NSV)) bus ();

    svm_classify_engine #(.NF(NF), .FW(FW), .AW(AW), .NSV(NSV)) dut (
        .mClk    (mClk),
        .mResetn (mResetn),
        .bus     (bus)
    );

    typedef struct {
        int alpha;
        int x0;
        int x1;
        int y;
    } sv_t;

    typedef struct {
        longint bias;
        int     xt0;
        int     xt1;
        longint exp_score;
        int     exp_class;
    } vec_t;

    sv_t model_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference decision value straight from the defining sum.
    function automatic longint model_score(input longint b, input int xt0, input int xt1);
        longint s = b;
        foreach (model_q[i]) begin
            longint d = longint'(model_q[i].x0) * xt0 + longint'(model_q[i].x1) * xt1;
            longint t = longint'(model_q[i].alpha) * d;
            s += (model_q[i].y != 0) ? t : -t;
        end
        return s;
    endfunction

    function automatic int model_class(input longint s);
        return (s > 0) ? 1 : (s < 0) ? 3 : 0;
    endfunction

    function automatic int rand_feat();
        return int'($urandom_range(511, 0)) - 256;
    endfunction

    task automatic tick();
        @(posedge mClk);
        #1;
    endtask

    task automatic load_sv(input int a, input int x0, input int x1, input int y);
        bus.sv_alpha = AW'(a);
        bus.sv_x     = {FW'(x1), FW'(x0)};
        bus.sv_y     = y[0];
        bus.sv_wr    = 1'b1;
        tick();
        bus.sv_wr    = 1'b0;
        if (model_q.size() < NSV) model_q.push_back('{a, x0, x1, y});
    endtask

    task automatic clear_store();
        bus.sv_clear = 1'b1;
        tick();
        bus.sv_clear = 1'b0;
        model_q.delete();
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) begin
            load_sv(int'($urandom_range(511, 0)), rand_feat(), rand_feat(), int'($urandom_range(1, 0)));
        end
    endtask

    // Offers one test, waits (bounded) for the result, then consumes it.
    task automatic apply_stimulus(input int xt0, input int xt1, input longint b,
                                  output longint act_score, output int act_class, output int lat);
        bus.Xtest      = {FW'(xt1), FW'(xt0)};
        bus.bias       = ACC_W'(b);
        bus.test_valid = 1'b1;
        tick();
        bus.test_valid = 1'b0;
        bus.sv_wr      = 1'b0;
        lat = 0;
        while (!bus.class_valid && lat < 200) begin
            tick();
            lat++;
        end
        act_score = longint'($signed(bus.score));
        act_class = int'(bus.Class);
        bus.class_ready = 1'b1;
        tick();
        bus.class_ready = 1'b0;
    endtask

    task automatic run_and_check(input string name, input int xt0, input int xt1, input longint b);
        longint s;
        int     c;
        int     lat;
        longint e = model_score(b, xt0, xt1);
        int     n = model_q.size();
        apply_stimulus(xt0, xt1, b, s, c, lat);
        check_output({name, " score"}, s, e);
        check_output({name, " class"}, c, model_class(e));
        check_output({name, " latency"}, lat, (n == 0) ? 1 : n);
    endtask

    vec_t table_v[5];

    initial begin
        longint s;
        int     c;
        int     lat;
        longint e;
        int     n;

        bus.sv_wr = 0; bus.sv_alpha = '0; bus.sv_x = '0; bus.sv_y = 0; bus.sv_clear = 0;
        bus.bias = '0; bus.test_valid = 0; bus.Xtest = '0; bus.class_ready = 0;

        table_v[0] = '{0,   1,  1,  6, 1};
        table_v[1] = '{-6,  1,  1,  0, 0};
        table_v[2] = '{-10, 1,  1, -4, 3};
        table_v[3] = '{0,   2, -1, 15, 1};
        table_v[4] = '{3,  -1,  0, -4, 3};

        #2 mResetn = 1'b0;
        #10;
        check_output("reset class_valid", bus.class_valid, 0);
        check_output("reset Class", bus.Class, 0);
        check_output("reset score", longint'($signed(bus.score)), 0);
        check_output("reset sv_ready", bus.sv_ready, 1);
        check_output("reset test_ready", bus.test_ready, 1);
        check_output("reset sv_full", bus.sv_full, 0);
        check_output("reset sv_count", bus.sv_count, 0);
        @(negedge mClk);
        mResetn = 1'b1;
        tick();

        // Known vectors on the two-entry example store.
        load_sv(3, 2, 1, 1);
        load_sv(1, -1, 4, 0);
        check_output("basic sv_count", bus.sv_count, 2);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(table_v[i].xt0, table_v[i].xt1, table_v[i].bias, s, c, lat);
            check_output($sformatf("table[%0d] score", i), s, table_v[i].exp_score);
            check_output($sformatf("table[%0d] class", i), c, table_v[i].exp_class);
            check_output($sformatf("table[%0d] latency", i), lat, 2);
        end

        // Test and write together: the test wins, the write is dropped.
        bus.sv_wr = 1'b1;
        run_and_check("test+wr", 1, 1, 0);
        check_output("test+wr sv_count", bus.sv_count, 2);

        // Clear and write together: the clear wins.
        bus.sv_clear = 1'b1;
        bus.sv_wr    = 1'b1;
        tick();
        bus.sv_clear = 1'b0;
        bus.sv_wr    = 1'b0;
        model_q.delete();
        check_output("clear+wr sv_count", bus.sv_count, 0);

        // Empty store: result is just the bias.
        apply_stimulus(7, -3, -5, s, c, lat);
        check_output("empty score", s, -5);
        check_output("empty class", c, 3);
        check_output("empty latency", lat, 1);

        // Randomized stores and tests against the model.
        for (int r = 0; r < 4; r++) begin
            clear_store();
            load_random(int'($urandom_range(8, 1)));
            check_output($sformatf("rand%0d sv_count", r), bus.sv_count, model_q.size());
            for (int t = 0; t < 4; t++) begin
                run_and_check($sformatf("rand%0d.%0d", r, t), rand_feat(), rand_feat(),
                              longint'(int'($urandom)));
            end
        end

        // Backpressure, and a write during ACCUM.
        clear_store();
        load_random(4);
        bus.Xtest      = {FW'(5), FW'(-9)};
        bus.bias       = ACC_W'(longint'(17));
        bus.test_valid = 1'b1;
        tick();
        bus.test_valid = 1'b0;
        e = model_score(17, -9, 5);
        check_output("accum test_ready", bus.test_ready, 0);
        bus.sv_wr = 1'b1;
        tick();
        bus.sv_wr = 1'b0;
        check_output("accum wr sv_count", bus.sv_count, 4);
        n = 0;
        while (!bus.class_valid && n < 200) begin
            tick();
            n++;
        end
        check_output("bp class_valid", bus.class_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("bp%0d score", i), longint'($signed(bus.score)), e);
            check_output($sformatf("bp%0d class", i), bus.Class, model_class(e));
            check_output($sformatf("bp%0d test_ready", i), bus.test_ready, 0);
            tick();
        end
        bus.class_ready = 1'b1;
        tick();
        bus.class_ready = 1'b0;
        check_output("bp release test_ready", bus.test_ready, 1);

        // Full store: the 65th write is ignored and all 64 terms are summed.
        clear_store();
        load_random(NSV + 1);
        check_output("full sv_count", bus.sv_count, NSV);
        check_output("full sv_full", bus.sv_full, 1);
        check_output("full sv_ready", bus.sv_ready, 0);
        run_and_check("full", rand_feat(), rand_feat(), longint'(int'($urandom)));

        // Reset during ACCUM takes effect without a clock edge.
        clear_store();
        load_random(4);
        bus.Xtest      = {FW'(1), FW'(1)};
        bus.bias       = '0;
        bus.test_valid = 1'b1;
        tick();
        bus.test_valid = 1'b0;
        tick();
        mResetn = 1'b0;
        #1;
        check_output("rst accum class_valid", bus.class_valid, 0);
        check_output("rst accum sv_count", bus.sv_count, 0);
        check_output("rst accum test_ready", bus.test_ready, 1);
        model_q.delete();
        @(negedge mClk);
        mResetn = 1'b1;
        tick();
        run_and_check("post-reset", 3, 4, -8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
